stl_rr_lock_arbiter: RTL

- Round-robin arbiter that shares one downstream burst channel among N requesters.
- Arbitrates only when the channel is idle, then locks the grant until the winner's last beat transfers.
- Publishes the grant both as a one-hot vector and as a binary index, so downstream muxes and the one-hot-to-binary checkers see consistent views.
- Sits between requester ports and a shared bus or memory port in the Common library.

---
 rtl/stl_rr_lock_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/stl_rr_lock_arbiter.sv
// Round-robin arbiter that locks the winner onto one shared burst channel until its last beat.
// Grant registered one cycle after request; burst data path is combinational; out_ready_i low stalls the granted requester.
module stl_rr_lock_arbiter #(
  parameter int N     = 4,
  parameter int IDXW  = 2,
  parameter int BCNTW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     last_i,
  output logic [N-1:0]     gnt_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDXW-1:0]  grant_idx_o,
  output logic             busy_o,
  output logic [BCNTW-1:0] beats_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      grant_oh_q, grant_oh_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic [BCNTW-1:0]  beats_q, beats_d;

  logic              found;
  logic [IDXW-1:0]   win;
  logic [IDXW-1:0]   cand;
  logic              xfer;

  // Rotating priority scan; index arithmetic wraps because N is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDXW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign out_valid_o = busy_o & req_i[grant_idx_q];
  assign out_last_o  = busy_o & last_i[grant_idx_q];
  assign xfer        = out_valid_o & out_ready_i;
  assign gnt_o       = grant_oh_q & {N{out_ready_i}};
  assign grant_oh_o  = grant_oh_q;
  assign grant_idx_o = grant_idx_q;
  assign beats_o     = beats_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    beats_d     = beats_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = BUSY;
          grant_oh_d       = '0;
          grant_oh_d[win]  = 1'b1;
          grant_idx_d      = win;
          beats_d          = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (beats_q != {BCNTW{1'b1}}) beats_d = beats_q + 1'b1;
          // Beat count is kept after release so it stays observable until the next grant.
          if (out_last_o) begin
            state_d     = IDLE;
            grant_oh_d  = '0;
            grant_idx_d = '0;
            ptr_d       = grant_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      beats_q     <= beats_d;
    end
  end

  a_oh_match: assert property (@(posedge clk) disable iff (rst)
    busy_o |-> (grant_oh_q == (N'(1) << grant_idx_q)));
  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_oh_q));
  a_req_held: assert property (@(posedge clk) disable iff (rst) busy_o |-> req_i[grant_idx_q])
    else $warning("granted requester dropped its request before the last beat");

endmodule
